// File: rtl/bf2_sdf_stage.sv
// bf2_sdf_stage: radix-2 single-path delay-feedback butterfly stage with D=2^DEPTH_LOG2 feedback delay.
// Define BF2_SDF_STAGE_SAT_EN to saturate sums/differences instead of wrapping them.
module bf2_sdf_stage #(
    parameter int DATA_WIDTH = 13,
    parameter int ADD_G      = 1,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic signed [DATA_WIDTH-ADD_G-1:0]  in_r,
    input  logic signed [DATA_WIDTH-ADD_G-1:0]  in_i,
    output logic                                out_valid,
    output logic signed [DATA_WIDTH-1:0]        out_r,
    output logic signed [DATA_WIDTH-1:0]        out_i,
    output logic                                s_out
);
    localparam int D = 1 << DEPTH_LOG2;
    localparam int W = DATA_WIDTH;
`ifdef BF2_SDF_STAGE_SAT_EN
    localparam int SW = W + 1;
    // overflow iff the two top bits disagree; clamp toward the sign
    function automatic logic signed [W-1:0] fit(input logic signed [SW-1:0] v);
        return (v[SW-1] == v[SW-2]) ? v[SW-2:0] : {v[SW-1], {(W-1){~v[SW-1]}}};
    endfunction
`else
    localparam int SW = W;
    function automatic logic signed [W-1:0] fit(input logic signed [SW-1:0] v);
        return v;
    endfunction
`endif
    logic [DEPTH_LOG2:0]   cnt;
    logic                  primed;
    logic                  s;
    logic signed [W-1:0]   dl_r [D];
    logic signed [W-1:0]   dl_i [D];
    logic signed [W-1:0]   ext_r, ext_i, head_r, head_i;
    logic signed [W-1:0]   res_r, res_i, din_r, din_i;
    logic signed [SW-1:0]  sum_r, sum_i, dif_r, dif_i;
    assign s      = cnt[DEPTH_LOG2];
    assign ext_r  = W'(in_r);
    assign ext_i  = W'(in_i);
    assign head_r = dl_r[D-1];
    assign head_i = dl_i[D-1];
    assign sum_r  = SW'(head_r) + SW'(ext_r);
    assign sum_i  = SW'(head_i) + SW'(ext_i);
    assign dif_r  = SW'(head_r) - SW'(ext_r);
    assign dif_i  = SW'(head_i) - SW'(ext_i);
    assign res_r  = s ? fit(sum_r) : head_r;
    assign res_i  = s ? fit(sum_i) : head_i;
    assign din_r  = s ? fit(dif_r) : ext_r;
    assign din_i  = s ? fit(dif_i) : ext_i;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            s_out     <= 1'b0;
            for (int k = 0; k < D; k++) begin
                dl_r[k] <= '0;
                dl_i[k] <= '0;
            end
        end else begin
            out_valid <= in_valid && primed;
            if (in_valid) begin
                cnt    <= cnt + 1'b1;
                primed <= primed | (cnt == (DEPTH_LOG2+1)'(D-1));
                out_r  <= res_r;
                out_i  <= res_i;
                s_out  <= s;
                dl_r[0] <= din_r;
                dl_i[0] <= din_i;
                for (int k = 1; k < D; k++) begin
                    dl_r[k] <= dl_r[k-1];
                    dl_i[k] <= dl_i[k-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_bf2_sdf_stage.sv
// tb_bf2_sdf_stage: scoreboard bench for bf2_sdf_stage (D=2, D=1/8-bit, D=8 random); honours BF2_SDF_STAGE_SAT_EN.
module tb_bf2_sdf_stage;
    typedef struct {int r; int i; bit s;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    logic a_iv = 1'b0, b_iv = 1'b0, c_iv = 1'b0;
    logic signed [11:0] a_ir = '0, a_ii = '0, c_ir = '0, c_ii = '0;
    logic signed [7:0]  b_ir = '0, b_ii = '0;
    logic a_ov, b_ov, c_ov, a_s, b_s, c_s;
    logic signed [12:0] a_or, a_oi, c_or, c_oi;
    logic signed [7:0]  b_or, b_oi;
    exp_t qa[$], qb[$], qc[$];
    int ha_r[$], ha_i[$], hb_r[$], hb_i[$], hc_r[$], hc_i[$];

    bf2_sdf_stage #(.DATA_WIDTH(13), .ADD_G(1), .DEPTH_LOG2(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_r(a_ir), .in_i(a_ii),
        .out_valid(a_ov), .out_r(a_or), .out_i(a_oi), .s_out(a_s));
    bf2_sdf_stage #(.DATA_WIDTH(8), .ADD_G(0), .DEPTH_LOG2(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_r(b_ir), .in_i(b_ii),
        .out_valid(b_ov), .out_r(b_or), .out_i(b_oi), .s_out(b_s));
    bf2_sdf_stage #(.DATA_WIDTH(13), .ADD_G(1), .DEPTH_LOG2(3)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_r(c_ir), .in_i(c_ii),
        .out_valid(c_ov), .out_r(c_or), .out_i(c_oi), .s_out(c_s));

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int fit(input int v, input int dw);
        int h;
        int m;
        h = 1 << (dw - 1);
`ifdef BF2_SDF_STAGE_SAT_EN
        m = (v >= h) ? h - 1 : (v < -h) ? -h : v;
`else
        m = v & ((h << 1) - 1);
        if (m >= h) m = m - 2 * h;
`endif
        return m;
    endfunction

    // frame view: sums x[k]+x[k+D] in 2nd half of a frame, differences x[k]-x[k+D] in 1st half of the next
    function automatic bit predict(input int d, input int dw, input int hr[$], input int hi[$], output exp_t e);
        int n;
        int k;
        n = hr.size() - 1;
        k = n % (2 * d);
        e = '{0, 0, 1'b0};
        if (k >= d) begin
            e = '{fit(hr[n-d] + hr[n], dw), fit(hi[n-d] + hi[n], dw), 1'b1};
            return 1'b1;
        end
        if (n >= 2 * d) begin
            e = '{fit(hr[n-2*d] - hr[n-d], dw), fit(hi[n-2*d] - hi[n-d], dw), 1'b0};
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic put_a(input int r, input int i);
        exp_t e;
        a_iv = 1'b1; a_ir = 12'(r); a_ii = 12'(i);
        ha_r.push_back(r); ha_i.push_back(i);
        if (predict(2, 13, ha_r, ha_i, e)) qa.push_back(e);
        @(negedge clk);
    endtask

    task automatic put_b(input int r, input int i);
        exp_t e;
        b_iv = 1'b1; b_ir = 8'(r); b_ii = 8'(i);
        hb_r.push_back(r); hb_i.push_back(i);
        if (predict(1, 8, hb_r, hb_i, e)) qb.push_back(e);
        @(negedge clk);
    endtask

    task automatic put_c(input int r, input int i);
        exp_t e;
        c_iv = 1'b1; c_ir = 12'(r); c_ii = 12'(i);
        hc_r.push_back(r); hc_i.push_back(i);
        if (predict(8, 13, hc_r, hc_i, e)) qc.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        chk("a_left", qa.size(), 0);
        chk("b_left", qb.size(), 0);
        chk("c_left", qc.size(), 0);
        rst = 1'b1;
        #1;
        chk("rst_a_ov", a_ov, 0); chk("rst_a_or", a_or, 0); chk("rst_a_oi", a_oi, 0); chk("rst_a_s", a_s, 0);
        chk("rst_b_ov", b_ov, 0); chk("rst_b_or", b_or, 0);
        chk("rst_c_ov", c_ov, 0); chk("rst_c_or", c_or, 0);
        qa.delete(); qb.delete(); qc.delete();
        ha_r.delete(); ha_i.delete(); hb_r.delete(); hb_i.delete(); hc_r.delete(); hc_i.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin : mon_a
        exp_t e;
        #1;
        if (a_ov) begin
            if (qa.size() == 0) chk("a_extra", a_ov, 0);
            else begin
                e = qa.pop_front();
                chk("a_r", a_or, e.r); chk("a_i", a_oi, e.i); chk("a_s", a_s, e.s);
            end
        end
    end

    always @(posedge clk) begin : mon_b
        exp_t e;
        #1;
        if (b_ov) begin
            if (qb.size() == 0) chk("b_extra", b_ov, 0);
            else begin
                e = qb.pop_front();
                chk("b_r", b_or, e.r); chk("b_i", b_oi, e.i); chk("b_s", b_s, e.s);
            end
        end
    end

    always @(posedge clk) begin : mon_c
        exp_t e;
        #1;
        if (c_ov) begin
            if (qc.size() == 0) chk("c_extra", c_ov, 0);
            else begin
                e = qc.pop_front();
                chk("c_r", c_or, e.r); chk("c_i", c_oi, e.i); chk("c_s", c_s, e.s);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int sa_r[6];
        int sa_i[6];
        sa_r = '{1, 2, 3, 4, 0, 0};
        sa_i = '{5, -3, 0, 7, 0, 0};
        @(negedge clk);
        do_reset();
        foreach (sa_r[k]) put_a(sa_r[k], sa_i[k]);
        idle(3);
        do_reset();
        foreach (sa_r[k]) begin
            put_a(sa_r[k], sa_i[k]);
            idle(3);
        end
        do_reset();
        for (int k = 0; k < 3; k++) put_a(sa_r[k], sa_i[k]);
        do_reset();
        put_a(5, 1); put_a(6, -2); put_a(7, 3); put_a(8, -4); put_a(0, 0); put_a(0, 0);
        idle(3);
        do_reset();
        put_b(100, -100); put_b(100, -100); put_b(-100, 50); put_b(-100, 60);
        put_b(100, -1); put_b(-100, 1); put_b(0, 0); put_b(0, 0);
        idle(3);
        do_reset();
        for (int k = 0; k < 64 * 16; k++) begin
            put_c(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
            if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 2)));
        end
        for (int k = 0; k < 8; k++) put_c(0, 0);
        idle(4);
        chk("a_left", qa.size(), 0);
        chk("b_left", qb.size(), 0);
        chk("c_left", qc.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bf2_sdf_stage.md
BF2_SDF_STAGE -- requirements
Module: bf2_sdf_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 13: width of the output and delay-line word.
REQ-002 Parameter ADD_G, default 1: bit growth of the stage; the input width is DATA_WIDTH-ADD_G; legal values are 0 and 1.
REQ-003 Parameter DEPTH_LOG2, default 3: the feedback delay depth is D = 2^DEPTH_LOG2 samples; legal range is 0..10.
REQ-004 Port clk, input, 1: the single clock; every register samples on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1: in_r/in_i hold a sample this cycle.
REQ-007 Ports in_r and in_i, input, DATA_WIDTH-ADD_G: two's-complement real and imaginary input sample.
REQ-008 Port out_valid, output, 1: out_r/out_i hold a valid result.
REQ-009 Ports out_r and out_i, output, DATA_WIDTH: two's-complement real and imaginary result.
REQ-010 Port s_out, output, 1: butterfly select that applied to the sample now on the output, for twiddle/next-stage control.

Function
REQ-011 Input extension: when ADD_G=1, ext = in sign-extended by 1 bit; when ADD_G=0, ext = in.
REQ-012 Counter cnt, DEPTH_LOG2+1 bits, increments by 1 per accepted sample (in_valid=1) and wraps from 2D-1 to 0; s = cnt[DEPTH_LOG2].
REQ-013 Delay line: D words per component, realised as a shift register or circular RAM; it advances only on accepted samples; head = the oldest word.
REQ-014 On an accepted sample with s=0: delay input = ext; result = head.
REQ-015 On an accepted sample with s=1: delay input = head - ext; result = head + ext.
REQ-016 The result is truncated to DATA_WIDTH low bits (wrap) unless REQ-027 applies.
REQ-017 out_r/out_i/s_out are registered; latency is 1 clock from an accepted sample to its out_valid.
REQ-018 A primed flag sets after D accepted samples.
REQ-019 out_valid = registered (in_valid and primed-before-this-sample); the first D accepted samples after reset produce no out_valid.
REQ-020 With in_valid=0: cnt, the delay line, primed and out_r/out_i hold; out_valid=0 the next cycle; gaps of any length are permitted.
REQ-021 Sample order: frame f sums appear during s=1 of frame f; frame f differences appear during s=0 of frame f+1, so the last frame's differences emerge only when further samples are pushed.
REQ-022 When D=1 (DEPTH_LOG2=0), s alternates every accepted sample and the delay line is a single register.

Reset
REQ-023 While rst=1, cnt=0, primed=0, every delay-line word=0, out_valid=0, out_r=0, out_i=0 and s_out=0, asynchronously.
REQ-024 Reset asserted mid-frame discards all partial frame state; the first accepted sample after deassertion is sample 0 of frame 0.
REQ-025 Reset deassertion takes effect at the next rising clk edge; a sample presented in that cycle is accepted.

Configuration
REQ-026 The macro BF2_SDF_STAGE_SAT_EN controls result saturation.
REQ-027 With BF2_SDF_STAGE_SAT_EN defined, the sum and difference are computed at DATA_WIDTH+1 bits and saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before they are output or stored.
REQ-028 Without BF2_SDF_STAGE_SAT_EN, results wrap per REQ-016; with ADD_G=1 and in-range inputs, the two builds are bit-identical.

Verification
REQ-029 Scenario (DEPTH_LOG2=1, ADD_G=1): real inputs 1,2,3,4,0,0 contiguous -> valid out_r sequence 4,6,-2,-2 with s_out 1,1,0,0; no out_valid for the first two inputs.
REQ-030 Scenario: same stream as REQ-029 with in_valid=0 gaps of 3 cycles between samples -> identical valid output sequence; out_valid never asserted during gaps.
REQ-031 Scenario: rst pulsed after input 3 of the REQ-029 stream, then 5,6,7,8,0,0 -> outputs 12,14,-2,-2 and no stale data.
REQ-032 Scenario (ADD_G=0, DATA_WIDTH=8): inputs 100 then 100 (D=1) -> out 200 wraps to -56 without the macro; 127 with BF2_SDF_STAGE_SAT_EN.
REQ-033 Scenario: random complex stream, D=8, 64 frames -> outputs match a software radix-2 SDF reference model bit-exactly.
